bcd_countdown: RTL and testbench
================================

# bcd_countdown

Multi-digit BCD down-counter with preload, start/pause control and a terminal-count strobe. It is the decrementing counterpart of the team's decade up-counters: it consumes the same single-cycle count-enable ticks and produces a one-cycle done pulse when the preloaded value reaches zero. It sits between the tick generator and control logic that needs countdown timeouts expressed in decimal, for example for display.

## Interface
- DIGITS, default 4: number of BCD digits. Counter width is 4*DIGITS.

- iClk  in  1  rising-edge clock
- iRst  in  1  asynchronous, active-low reset
- iLoad  in  1  preload strobe; samples iValue
- iValue  in  4*DIGITS  BCD preload value; digit 0 is bits [3:0]
- iStart  in  1  start or resume countdown
- iStop  in  1  pause countdown
- iC  in  1  count-enable tick; one decrement per sampled high cycle
- oS  out  4*DIGITS  current BCD value (registered)
- oBusy  out  1  high while in state RUN
- oDone  out  1  one-cycle pulse on reaching zero
- oErr  out  1  sticky flag: last load attempt contained a non-BCD digit

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Reset** (iRst low, asynchronous):
  - state = IDLE
  - oS = 0, oBusy = 0, oDone = 0, oErr = 0
- **Command priority** within one cycle: iLoad > iStop > iStart > iC.
- **iLoad, any state:**
  - All digits of iValue ≤ 9: oS <= iValue, oErr <= 0, state <= IDLE.
  - Otherwise: oS and state unchanged, oErr <= 1.
- **iStart in IDLE or PAUSE:**
  - oS != 0: state <= RUN.
  - oS == 0: state <= DONE and oDone pulses.
- **iStart in DONE:**
  - oS == 0: re-enter DONE and pulse oDone again.
  - This is the only way to retrigger DONE without a load.
- **iStart in RUN:** ignored.
- **iStop in RUN:** state <= PAUSE. A concurrent iC is dropped; no decrement occurs.
- **iStop in any other state:** ignored.
- **RUN with iC high:** BCD decrement with borrow ripple.
  - Digit 0 decrements. A digit at 0 wraps to 9 and borrows from the next digit.
  - All digits are resolved in the same cycle.
- **Reaching zero:**
  - Applies when the decrement takes oS to 0, i.e. the only nonzero digit is digit 0 and it equals 1.
  - state <= DONE, and oDone pulses on the same edge that oS becomes 0.
- **iC outside RUN:** ignored; oS holds.
- **Wrap-around:** never occurs. The counter does not decrement below 0, and zero always forces DONE.
- **oBusy:** exactly (state == RUN), registered.

## Timing
- Every output is registered. Each action updates on the first rising edge at which its input is sampled, so latency is 1 cycle.
- **oDone:**
  - High for exactly one cycle per zero event.
  - It is low in the cycle after, even if state stays DONE.
- **Back-to-back iC** every cycle: oS decrements every cycle.
  - From a preload of N with a single start, the done pulse occurs N iC-ticks after entering RUN.
- **Load mid-count:** iLoad during RUN aborts the countdown.
  - Next cycle: new value present, state IDLE, oBusy low.
  - Any concurrent iC is dropped.
- **Reset mid-operation:** outputs clear immediately, asynchronously, with no clock edge required. The first command is accepted on the first edge after iRst rises.

## Test plan
- **Basic countdown and borrow** (DIGITS=2): load 8'h10, iStart, one iC.
  - oS = 8'h09, oBusy = 1.
  - Nine more iC: oS = 8'h00, oDone pulses once, state DONE, oBusy = 0.
- **Multi-digit borrow ripple** (DIGITS=4): load 16'h1000, start, one iC.
  - oS = 16'h0999 after 1 cycle.
- **Pause/resume with collision:** in RUN at 8'h05, assert iStop and iC together.
  - oS stays 8'h05, state PAUSE.
  - iC pulses while paused: no change.
  - iStart, then 5 iC: oDone pulses, oS = 0.
- **Invalid preload:** load 8'h3A.
  - oErr = 1, oS unchanged.
  - Load 8'h42: oErr = 0, oS = 8'h42.
- **Zero start and DONE retrigger:** load 0, iStart.
  - Next cycle oDone = 1, state DONE, oBusy never high.
  - iStart again: oDone pulses again.
- **Async reset mid-RUN:** at oS = 8'h37, drop iRst between clock edges.
  - oS = 0, oBusy = 0, oErr = 0 immediately.
  - After release, iC has no effect until a load and start.

Source files
------------

// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with preload, start/pause control, a one-cycle
// done strobe on reaching zero and a sticky invalid-preload flag.
module bcd_countdown #(
  parameter int DIGITS = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iLoad,
  input  logic [4*DIGITS-1:0]   iValue,
  input  logic                  iStart,
  input  logic                  iStop,
  input  logic                  iC,
  output logic [4*DIGITS-1:0]   oS,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr,
  output logic [1:0]            oState
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         stateNext;
  logic [W-1:0]   sNext;
  logic [W-1:0]   sDec;
  logic           doneNext;
  logic           errNext;
  logic           valueOk;

  function automatic logic allBcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Borrow ripples from digit 0 upward; a zero digit under borrow becomes 9.
  function automatic logic [W-1:0] bcdDec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign valueOk = allBcd(iValue);
  assign sDec    = bcdDec(oS);
  assign oState  = state;

  // Ignored commands do not block lower-priority ones; priority only
  // matters between commands that would each take effect.
  always_comb begin
    stateNext = state;
    sNext     = oS;
    doneNext  = 1'b0;
    errNext   = oErr;
    if (iLoad) begin
      if (valueOk) begin
        sNext     = iValue;
        errNext   = 1'b0;
        stateNext = IDLE;
      end else begin
        errNext   = 1'b1;
      end
    end else if (iStop && (state == RUN)) begin
      stateNext = PAUSE;
    end else if (iStart && ((state == IDLE) || (state == PAUSE))) begin
      if (oS != '0) begin
        stateNext = RUN;
      end else begin
        stateNext = DONE;
        doneNext  = 1'b1;
      end
    end else if (iStart && (state == DONE) && (oS == '0)) begin
      stateNext = DONE;
      doneNext  = 1'b1;
    end else if (iC && (state == RUN)) begin
      sNext = sDec;
      if (sDec == '0) begin
        stateNext = DONE;
        doneNext  = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= IDLE;
      oS    <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oErr  <= 1'b0;
    end else begin
      state <= stateNext;
      oS    <= sNext;
      oBusy <= (stateNext == RUN);
      oDone <= doneNext;
      oErr  <= errNext;
    end
  end

endmodule

// File: tb/tb_bcd_countdown.sv
// Vector-table bench for bcd_countdown (DIGITS=4): each record is one clock of
// commands plus the outputs expected after that edge, checked via a queue.
module tb_bcd_countdown;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = W + 5;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic          iClk;
  logic          iRst;
  logic          iLoad;
  logic [W-1:0]  iValue;
  logic          iStart;
  logic          iStop;
  logic          iC;
  logic [W-1:0]  oS;
  logic          oBusy;
  logic          oDone;
  logic          oErr;
  logic [1:0]    oState;

  typedef struct {
    logic         load;
    logic [W-1:0] value;
    logic         start;
    logic         stop;
    logic         c;
    logic [W-1:0] expS;
    logic         expBusy;
    logic         expDone;
    logic         expErr;
    logic [1:0]   expState;
  } vec_t;

  vec_t            vecs[$];
  logic [EW-1:0]   exp_q[$];
  int              checks = 0;
  int              errors = 0;

  bcd_countdown #(.DIGITS(DIGITS)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iLoad  (iLoad),
    .iValue (iValue),
    .iStart (iStart),
    .iStop  (iStop),
    .iC     (iC),
    .oS     (oS),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oErr   (oErr),
    .oState (oState)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic addVec(input logic load, input logic [W-1:0] value,
                        input logic start, input logic stop, input logic c,
                        input logic [W-1:0] expS, input logic expBusy,
                        input logic expDone, input logic expErr,
                        input logic [1:0] expState);
    vec_t v;
    v.load = load;   v.value = value; v.start = start; v.stop = stop; v.c = c;
    v.expS = expS;   v.expBusy = expBusy; v.expDone = expDone;
    v.expErr = expErr; v.expState = expState;
    vecs.push_back(v);
  endtask

  task automatic idleInputs();
    iLoad = 1'b0; iValue = '0; iStart = 1'b0; iStop = 1'b0; iC = 1'b0;
  endtask

  task automatic checkNow(input string name, input logic [EW-1:0] exp);
    logic [EW-1:0] act;
    act = {oS, oBusy, oDone, oErr, oState};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got S=%h busy=%b done=%b err=%b state=%0d, want S=%h busy=%b done=%b err=%b state=%0d",
               name, act[EW-1:5], act[4], act[3], act[2], act[1:0],
               exp[EW-1:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // driver: called at a negedge, drives one cycle, compares after the posedge
  task automatic applyVec(input int idx, input string tag);
    vec_t v;
    v = vecs[idx];
    iLoad = v.load; iValue = v.value; iStart = v.start; iStop = v.stop; iC = v.c;
    exp_q.push_back({v.expS, v.expBusy, v.expDone, v.expErr, v.expState});
    @(posedge iClk);
    #2;
    checkNow($sformatf("%s[%0d]", tag, idx), exp_q.pop_front());
    @(negedge iClk);
  endtask

  initial begin
    int base;
    idleInputs();
    iRst = 1'b0;
    #12;
    checkNow("reset", {16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE});
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);

    // basic countdown with borrow from 0010
    addVec(1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0, S_IDLE);
    addVec(0, '0,       1, 0, 0, 16'h0010, 1, 0, 0, S_RUN);
    addVec(0, '0,       0, 0, 1, 16'h0009, 1, 0, 0, S_RUN);
    for (int k = 8; k >= 1; k--)
      addVec(0, '0, 0, 0, 1, W'(k), 1, 0, 0, S_RUN);
    addVec(0, '0, 0, 0, 1, 16'h0000, 0, 1, 0, S_DONE);
    addVec(0, '0, 0, 0, 0, 16'h0000, 0, 0, 0, S_DONE);
    addVec(0, '0, 0, 0, 1, 16'h0000, 0, 0, 0, S_DONE);
    addVec(0, '0, 1, 0, 0, 16'h0000, 0, 1, 0, S_DONE);
    addVec(0, '0, 0, 0, 0, 16'h0000, 0, 0, 0, S_DONE);
    // full-width borrow ripple, then load mid-count drops concurrent iC
    addVec(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, S_IDLE);
    addVec(0, '0,       1, 0, 0, 16'h1000, 1, 0, 0, S_RUN);
    addVec(0, '0,       0, 0, 1, 16'h0999, 1, 0, 0, S_RUN);
    addVec(1, 16'h0005, 0, 0, 1, 16'h0005, 0, 0, 0, S_IDLE);
    // pause with stop/iC collision, ticks while paused, resume to zero
    addVec(0, '0, 1, 0, 0, 16'h0005, 1, 0, 0, S_RUN);
    addVec(0, '0, 0, 1, 1, 16'h0005, 0, 0, 0, S_PAUSE);
    addVec(0, '0, 0, 0, 1, 16'h0005, 0, 0, 0, S_PAUSE);
    addVec(0, '0, 0, 0, 1, 16'h0005, 0, 0, 0, S_PAUSE);
    addVec(0, '0, 0, 1, 0, 16'h0005, 0, 0, 0, S_PAUSE);
    addVec(0, '0, 1, 0, 0, 16'h0005, 1, 0, 0, S_RUN);
    for (int k = 4; k >= 1; k--)
      addVec(0, '0, 0, 0, 1, W'(k), 1, 0, 0, S_RUN);
    addVec(0, '0, 0, 0, 1, 16'h0000, 0, 1, 0, S_DONE);
    // invalid preload keeps value and state, valid one clears the flag
    addVec(1, 16'h003A, 0, 0, 0, 16'h0000, 0, 0, 1, S_DONE);
    addVec(0, '0,       0, 0, 0, 16'h0000, 0, 0, 1, S_DONE);
    addVec(1, 16'h0042, 0, 0, 0, 16'h0042, 0, 0, 0, S_IDLE);
    // zero start and DONE retrigger
    addVec(1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, S_IDLE);
    addVec(0, '0,       1, 0, 0, 16'h0000, 0, 1, 0, S_DONE);
    addVec(0, '0,       0, 0, 0, 16'h0000, 0, 0, 0, S_DONE);
    addVec(0, '0,       1, 0, 0, 16'h0000, 0, 1, 0, S_DONE);
    addVec(0, '0,       0, 0, 0, 16'h0000, 0, 0, 0, S_DONE);
    // priority: load beats start, start beats iC in IDLE, start ignored in RUN
    addVec(1, 16'h0050, 1, 0, 0, 16'h0050, 0, 0, 0, S_IDLE);
    addVec(0, '0,       1, 0, 1, 16'h0050, 1, 0, 0, S_RUN);
    addVec(0, '0,       1, 0, 1, 16'h0049, 1, 0, 0, S_RUN);
    // bad upper digit while running: flag set, countdown continues
    addVec(1, 16'hA000, 0, 0, 0, 16'h0049, 1, 0, 1, S_RUN);
    addVec(0, '0,       0, 0, 1, 16'h0048, 1, 0, 1, S_RUN);
    // set up 0037 in RUN with the error flag set
    addVec(1, 16'h0038, 0, 0, 0, 16'h0038, 0, 0, 0, S_IDLE);
    addVec(0, '0,       1, 0, 0, 16'h0038, 1, 0, 0, S_RUN);
    addVec(0, '0,       0, 0, 1, 16'h0037, 1, 0, 0, S_RUN);
    addVec(1, 16'h00F0, 0, 0, 0, 16'h0037, 1, 0, 1, S_RUN);

    for (int i = 0; i < vecs.size(); i++) applyVec(i, "vec");

    // asynchronous reset between edges
    @(posedge iClk);
    #3;
    iRst = 1'b0;
    #1;
    checkNow("async_reset", {16'h0000, 1'b0, 1'b0, 1'b0, S_IDLE});
    @(negedge iClk);
    iRst = 1'b1;

    base = vecs.size();
    addVec(0, '0, 0, 0, 1, 16'h0000, 0, 0, 0, S_IDLE);
    addVec(0, '0, 0, 0, 1, 16'h0000, 0, 0, 0, S_IDLE);
    addVec(1, 16'h0002, 0, 0, 1, 16'h0002, 0, 0, 0, S_IDLE);
    addVec(0, '0, 0, 0, 1, 16'h0002, 0, 0, 0, S_IDLE);
    addVec(0, '0, 1, 0, 0, 16'h0002, 1, 0, 0, S_RUN);
    addVec(0, '0, 0, 0, 1, 16'h0001, 1, 0, 0, S_RUN);
    addVec(0, '0, 0, 0, 1, 16'h0000, 0, 1, 0, S_DONE);
    addVec(0, '0, 0, 0, 0, 16'h0000, 0, 0, 0, S_DONE);
    for (int i = base; i < vecs.size(); i++) applyVec(i, "post_reset");

    idleInputs();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
